// File: rtl/tdm_demux_if.sv
// Link bundle for the TDM receive end: serial sample side in, rebuilt frame and
// alignment status out.
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 1
);
  logic [DATA_W-1:0]          din;
  logic                       din_valid;
  logic                       frame_sync;
  logic [CHANNELS*DATA_W-1:0] y;
  logic                       frame_valid;
  logic [SEL_W-1:0]           s;
  logic                       locked;
  logic                       sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  y, frame_valid, s, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y, frame_valid, s, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: aligns to frame_sync, collects one sample per slot
// into a shadow word and publishes each complete in-order frame with a strobe.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_demux_if.slave link
);

  typedef enum logic {HUNT, LOCK} state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

  state_t                     state;
  logic [CHANNELS*DATA_W-1:0] shadow;
  logic [CHANNELS*DATA_W-1:0] frame_word;

  // Final slot bypasses the shadow so y loads on the same edge it is sampled.
  always_comb begin
    frame_word = shadow;
    frame_word[(CHANNELS-1)*DATA_W +: DATA_W] = link.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= HUNT;
      shadow           <= '0;
      link.y           <= '0;
      link.frame_valid <= 1'b0;
      link.s           <= '0;
      link.locked      <= 1'b0;
      link.sync_err    <= 1'b0;
    end else begin
      link.frame_valid <= 1'b0;
      link.sync_err    <= 1'b0;
      if (link.din_valid) begin
        unique case (state)
          HUNT: begin
            if (link.frame_sync) begin
              shadow[0 +: DATA_W] <= link.din;
              link.s              <= SEL_W'(1);
              link.locked         <= 1'b1;
              state               <= LOCK;
            end
          end
          LOCK: begin
            if (link.frame_sync) begin
              // Sync away from slot 0 restarts the frame; the partial one is dropped.
              link.sync_err       <= (link.s != '0);
              shadow[0 +: DATA_W] <= link.din;
              link.s              <= SEL_W'(1);
            end else if (link.s == '0) begin
              link.sync_err <= 1'b1;
              link.locked   <= 1'b0;
              state         <= HUNT;
            end else begin
              shadow[int'(link.s)*DATA_W +: DATA_W] <= link.din;
              if (link.s == LAST_SLOT) begin
                link.s           <= '0;
                link.y           <= frame_word;
                link.frame_valid <= 1'b1;
              end else begin
                link.s <= link.s + SEL_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: scenario tasks drive samples and check status;
// published frames are checked against a queue of expected words.
module tb_tdm_demux;

  logic clk;
  logic rst_n;

  int unsigned vectors;
  int unsigned miscompares;
  logic [3:0]  exp_q[$];
  logic [3:0]  last_y;

  tdm_demux_if #(.CHANNELS(4), .SEL_W(2), .DATA_W(1)) bus ();

  tdm_demux #(.CHANNELS(4), .SEL_W(2), .DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every frame_valid strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.frame_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_frame: y=%b, required no frame_valid", bus.y);
      end else begin
        logic [3:0] exp;
        exp = exp_q.pop_front();
        last_y = exp;
        if (bus.y !== exp) begin
          miscompares++;
          $display("FAIL frame_y: y=%b, required %b", bus.y, exp);
        end
      end
      vectors++;
      if (bus.sync_err !== 1'b0) begin
        miscompares++;
        $display("FAIL fv_and_err: sync_err=%b with frame_valid, required 0", bus.sync_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic d, input logic fs);
    @(negedge clk);
    bus.din        = d;
    bus.din_valid  = 1'b1;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    last_y         = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.y !== 4'b0000) begin miscompares++; $display("FAIL reset_y: y=%b, required 0000", bus.y); end
    vectors++;
    if (bus.s !== 2'd0) begin miscompares++; $display("FAIL reset_s: s=%0d, required 0", bus.s); end
    vectors++;
    if (bus.locked !== 1'b0 || bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: locked=%b fv=%b err=%b, required 0 0 0",
               bus.locked, bus.frame_valid, bus.sync_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    gap(1);
  endtask

  task automatic test_lock;
    exp_q.push_back(4'b1101);
    send(1'b1, 1'b1);
    vectors++;
    if (bus.locked !== 1'b1 || bus.s !== 2'd1) begin
      miscompares++;
      $display("FAIL lock_first: locked=%b s=%0d, required 1 1", bus.locked, bus.s);
    end
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    vectors++;
    if (bus.s !== 2'd3 || bus.frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_slot2: s=%0d fv=%b, required 3 0", bus.s, bus.frame_valid);
    end
    send(1'b1, 1'b0);
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.s !== 2'd0 || bus.y !== 4'b1101) begin
      miscompares++;
      $display("FAIL lock_publish: fv=%b s=%0d y=%b, required 1 0 1101",
               bus.frame_valid, bus.s, bus.y);
    end
    gap(1);
    vectors++;
    if (bus.frame_valid !== 1'b0 || bus.y !== 4'b1101) begin
      miscompares++;
      $display("FAIL lock_pulse_width: fv=%b y=%b, required 0 1101", bus.frame_valid, bus.y);
    end
  endtask

  task automatic test_gapped;
    logic [3:0] w;
    w = 4'b1101;
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      send(w[i], (i == 0));
      if (i < 3) begin
        gap(2);
        vectors++;
        if (bus.s !== 2'(i + 1) || bus.frame_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL gapped_hold_%0d: s=%0d fv=%b, required %0d 0",
                   i, bus.s, bus.frame_valid, i + 1);
        end
      end
    end
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.y !== 4'b1101) begin
      miscompares++;
      $display("FAIL gapped_publish: fv=%b y=%b, required 1 1101", bus.frame_valid, bus.y);
    end
    gap(2);
  endtask

  task automatic test_back_to_back;
    logic [3:0] frames [3];
    int         fv_count;
    frames[0] = 4'b0001;
    frames[1] = 4'b0110;
    frames[2] = 4'b1111;
    fv_count  = 0;
    for (int f = 0; f < 3; f++) exp_q.push_back(frames[f]);
    for (int n = 0; n < 12; n++) begin
      logic [3:0] w;
      w = frames[n / 4];
      send(w[n % 4], (n % 4 == 0));
      if (bus.frame_valid === 1'b1) fv_count++;
      vectors++;
      if (bus.frame_valid !== (n % 4 == 3)) begin
        miscompares++;
        $display("FAIL b2b_strobe_%0d: fv=%b, required %b", n + 1, bus.frame_valid, (n % 4 == 3));
      end
    end
    vectors++;
    if (fv_count != 3) begin
      miscompares++;
      $display("FAIL b2b_count: %0d strobes, required 3", fv_count);
    end
    gap(1);
  endtask

  task automatic test_early_sync;
    logic [3:0] y_before;
    y_before = last_y;
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    vectors++;
    if (bus.sync_err !== 1'b1 || bus.s !== 2'd1 || bus.locked !== 1'b1) begin
      miscompares++;
      $display("FAIL early_err: err=%b s=%0d locked=%b, required 1 1 1",
               bus.sync_err, bus.s, bus.locked);
    end
    vectors++;
    if (bus.y !== y_before || bus.frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_y_hold: y=%b fv=%b, required %b 0", bus.y, bus.frame_valid, y_before);
    end
    exp_q.push_back(4'b1011);
    send(1'b1, 1'b0);
    vectors++;
    if (bus.sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL early_err_width: err=%b, required 0", bus.sync_err);
    end
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.y !== 4'b1011) begin
      miscompares++;
      $display("FAIL early_recover: fv=%b y=%b, required 1 1011", bus.frame_valid, bus.y);
    end
    gap(1);
  endtask

  task automatic test_lost_sync;
    logic [3:0] w;
    w = 4'b0101;
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send(w[i], (i == 0));
    gap(1);
    send(1'b1, 1'b0);
    vectors++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.s !== 2'd0) begin
      miscompares++;
      $display("FAIL lost_err: err=%b locked=%b s=%0d, required 1 0 0",
               bus.sync_err, bus.locked, bus.s);
    end
    vectors++;
    if (bus.y !== 4'b0101 || bus.frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_y_hold: y=%b fv=%b, required 0101 0", bus.y, bus.frame_valid);
    end
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    vectors++;
    if (bus.locked !== 1'b0 || bus.s !== 2'd0 || bus.sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_ignore: locked=%b s=%0d err=%b, required 0 0 0",
               bus.locked, bus.s, bus.sync_err);
    end
    w = 4'b1001;
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send(w[i], (i == 0));
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.y !== 4'b1001 || bus.locked !== 1'b1) begin
      miscompares++;
      $display("FAIL lost_relock: fv=%b y=%b locked=%b, required 1 1001 1",
               bus.frame_valid, bus.y, bus.locked);
    end
    gap(1);
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] w;
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    #3;
    rst_n  = 1'b0;
    last_y = 4'b0000;
    #1;
    vectors++;
    if (bus.y !== 4'b0000 || bus.s !== 2'd0 || bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: y=%b s=%0d locked=%b, required 0000 0 0",
               bus.y, bus.s, bus.locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    vectors++;
    if (bus.locked !== 1'b0 || bus.s !== 2'd0 || bus.y !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_nolock: locked=%b s=%0d y=%b, required 0 0 0000",
               bus.locked, bus.s, bus.y);
    end
    w = 4'b0011;
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send(w[i], (i == 0));
    vectors++;
    if (bus.frame_valid !== 1'b1 || bus.y !== 4'b0011) begin
      miscompares++;
      $display("FAIL midreset_fresh: fv=%b y=%b, required 1 0011", bus.frame_valid, bus.y);
    end
    gap(2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_lock();
    test_gapped();
    test_back_to_back();
    test_early_sync();
    test_lost_sync();
    test_reset_mid_frame();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL frames_missing: %0d expected frames never published, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
